// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 memory arbiter: requester IDs, FSM
// encoding and default sizing.
package tiny16_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
    localparam int unsigned NUM_REQ              = 3;
    localparam int unsigned ADDR_W               = 16;
    localparam int unsigned DATA_W               = 16;

    typedef enum logic [1:0] {
        REQ_CPU = 2'd0,
        REQ_DMA = 2'd1,
        REQ_DSP = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(req_id_e id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the three requester ports and the synchronous-RAM port.
// Requesters hold req (and their we/addr/wdata) until they see their one-cycle
// ack; gnt marks the owner from the cycle after the decision until the ack.
interface mem_arbiter_if;
    import tiny16_pkg::*;

    logic              cpu_req,   dma_req,   dsp_req;
    logic              cpu_we,    dma_we,    dsp_we;
    logic [ADDR_W-1:0] cpu_addr,  dma_addr,  dsp_addr;
    logic [DATA_W-1:0] cpu_wdata, dma_wdata, dsp_wdata;
    logic              cpu_gnt,   dma_gnt,   dsp_gnt;
    logic              cpu_ack,   dma_ack,   dsp_ack;
    logic [DATA_W-1:0] rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, dma_req, dsp_req,
        input  cpu_we, dma_we, dsp_we,
        input  cpu_addr, dma_addr, dsp_addr,
        input  cpu_wdata, dma_wdata, dsp_wdata,
        input  mem_rdata,
        output cpu_gnt, dma_gnt, dsp_gnt,
        output cpu_ack, dma_ack, dsp_ack,
        output rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, dma_req, dsp_req,
        output cpu_we, dma_we, dsp_we,
        output cpu_addr, dma_addr, dsp_addr,
        output cpu_wdata, dma_wdata, dsp_wdata,
        output mem_rdata,
        input  cpu_gnt, dma_gnt, dsp_gnt,
        input  cpu_ack, dma_ack, dsp_ack,
        input  rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_select.sv
// Winner selection for the arbiter: fixed CPU > DMA > DSP priority, overridden
// by starvation counters on DMA/DSP with a last-served tiebreak between them.
module arb_select
    import tiny16_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               decide,
    input  logic [NUM_REQ-1:0] req,
    output req_id_e            win_id
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] dma_wait_q, dma_wait_d;
    logic [CNT_W-1:0] dsp_wait_q, dsp_wait_d;
    req_id_e          last_svc_q, last_svc_d;
    logic             dma_starved, dsp_starved;

    assign dma_starved = req[REQ_DMA] && (dma_wait_q == LIMIT);
    assign dsp_starved = req[REQ_DSP] && (dsp_wait_q == LIMIT);

    function automatic logic [CNT_W-1:0] next_wait(logic             is_req,
                                                   logic             won,
                                                   logic [CNT_W-1:0] cur);
        if (!is_req || won) begin
            return '0;
        end else if (cur == LIMIT) begin
            return cur;
        end else begin
            return cur + 1'b1;
        end
    endfunction

    always_comb begin
        win_id = REQ_CPU;
        if (dma_starved && dsp_starved) begin
            // Both starved: hand the slot to whichever was not served last.
            win_id = (last_svc_q == REQ_DMA) ? REQ_DSP : REQ_DMA;
        end else if (dma_starved) begin
            win_id = REQ_DMA;
        end else if (dsp_starved) begin
            win_id = REQ_DSP;
        end else if (req[REQ_CPU]) begin
            win_id = REQ_CPU;
        end else if (req[REQ_DMA]) begin
            win_id = REQ_DMA;
        end else if (req[REQ_DSP]) begin
            win_id = REQ_DSP;
        end
    end

    always_comb begin
        dma_wait_d = dma_wait_q;
        dsp_wait_d = dsp_wait_q;
        last_svc_d = last_svc_q;
        if (decide) begin
            dma_wait_d = next_wait(req[REQ_DMA], win_id == REQ_DMA, dma_wait_q);
            dsp_wait_d = next_wait(req[REQ_DSP], win_id == REQ_DSP, dsp_wait_q);
            if (win_id != REQ_CPU) begin
                last_svc_d = win_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_wait_q <= '0;
            dsp_wait_q <= '0;
            last_svc_q <= REQ_DSP;
        end else begin
            dma_wait_q <= dma_wait_d;
            dsp_wait_q <= dsp_wait_d;
            last_svc_q <= last_svc_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester arbiter for a single-port synchronous RAM. Each transaction
// runs IDLE (decide/latch) -> ACCESS (RAM cycle) -> RESP (ack + read data).
module mem_arbiter
    import tiny16_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    mem_arbiter_if.slave bus,
    output arb_state_e dbg_state
);

    arb_state_e        state_q, state_d;
    req_id_e           owner_q, owner_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [NUM_REQ-1:0] ack_vec;
    logic               decide;
    req_id_e            win_id;

    assign req_vec = {bus.dsp_req, bus.dma_req, bus.cpu_req};
    assign decide  = (state_q == ST_IDLE) && (|req_vec);

    arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clk    (clk),
        .rst    (rst),
        .decide (decide),
        .req    (req_vec),
        .win_id (win_id)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (decide) begin
                    state_d = ST_ACCESS;
                    owner_d = win_id;
                    // Capture the winner's command now; later input changes are ignored.
                    case (win_id)
                        REQ_DMA: begin
                            we_d    = bus.dma_we;
                            addr_d  = bus.dma_addr;
                            wdata_d = bus.dma_wdata;
                        end
                        REQ_DSP: begin
                            we_d    = bus.dsp_we;
                            addr_d  = bus.dsp_addr;
                            wdata_d = bus.dsp_wdata;
                        end
                        default: begin
                            we_d    = bus.cpu_we;
                            addr_d  = bus.cpu_addr;
                            wdata_d = bus.cpu_wdata;
                        end
                    endcase
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= REQ_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Outputs decode from the registered state, so reset clears them at once.
    assign gnt_vec = (state_q != ST_IDLE) ? id_to_onehot(owner_q) : '0;
    assign ack_vec = (state_q == ST_RESP) ? id_to_onehot(owner_q) : '0;

    assign bus.cpu_gnt = gnt_vec[REQ_CPU];
    assign bus.dma_gnt = gnt_vec[REQ_DMA];
    assign bus.dsp_gnt = gnt_vec[REQ_DSP];
    assign bus.cpu_ack = ack_vec[REQ_CPU];
    assign bus.dma_ack = ack_vec[REQ_DMA];
    assign bus.dsp_ack = ack_vec[REQ_DSP];

    assign bus.mem_en    = (state_q == ST_ACCESS);
    assign bus.mem_we    = bus.mem_en && we_q;
    assign bus.mem_addr  = bus.mem_en ? addr_q  : '0;
    assign bus.mem_wdata = bus.mem_en ? wdata_q : '0;
    assign bus.rdata     = ((state_q == ST_RESP) && !we_q) ? bus.mem_rdata : '0;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model and a
// grant-order scoreboard.
module tb_mem_arbiter;
    import tiny16_pkg::*;

    logic       clk;
    logic       rst;
    arb_state_e dbg_state;

    int n_checks;
    int n_errors;
    int dsp_ack_cnt;

    logic [2:0] exp_q[$];
    logic [2:0] gnt_obs;
    logic [2:0] ack_obs;

    logic [15:0] ram [0:255];
    logic [15:0] ram_rdata;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- synchronous RAM model ----------------
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            ram_rdata <= ram[bus.mem_addr[7:0]];
        end
    end
    assign bus.mem_rdata = ram_rdata;

    assign gnt_obs = {bus.dsp_gnt, bus.dma_gnt, bus.cpu_gnt};
    assign ack_obs = {bus.dsp_ack, bus.dma_ack, bus.cpu_ack};

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.dsp_req = 1'b0;
        bus.cpu_we  = 1'b0; bus.dma_we  = 1'b0; bus.dsp_we  = 1'b0;
        bus.cpu_addr  = '0; bus.dma_addr  = '0; bus.dsp_addr  = '0;
        bus.cpu_wdata = '0; bus.dma_wdata = '0; bus.dsp_wdata = '0;
    endtask

    // Waits for each ACCESS cycle and compares the owner against exp_q.
    task automatic run_grants(input int n);
        for (int k = 0; k < n; k++) begin
            int   budget;
            logic found;
            logic [2:0] exp;
            budget = 0;
            found  = 1'b0;
            while (!found && budget < 12) begin
                @(negedge clk);
                budget++;
                if (dbg_state == ST_ACCESS) found = 1'b1;
            end
            check($sformatf("grant_seen_%0d", k), {15'd0, found}, 16'd1);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
            if (found) check($sformatf("grant_order_%0d", k), {13'd0, gnt_obs}, {13'd0, exp});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks    = 0;
        n_errors    = 0;
        dsp_ack_cnt = 0;
        rst         = 1'b0;
        pre_we      = 1'b1;
        pre_addr    = 8'h10;
        pre_data    = 16'hBEEF;
        idle_inputs();

        // Reset state
        step(1);
        pre_we = 1'b0;
        check("rst_state",  {14'd0, dbg_state}, {14'd0, ST_IDLE});
        check("rst_gnt",    {13'd0, gnt_obs}, 16'd0);
        check("rst_ack",    {13'd0, ack_obs}, 16'd0);
        check("rst_mem_en", {15'd0, bus.mem_en}, 16'd0);
        check("rst_rdata",  bus.rdata, 16'd0);
        step(1);
        rst = 1'b1;
        step(1);

        // Single CPU read of 0x0010
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        step(1);
        check("rd_gnt",      {13'd0, gnt_obs}, 16'h0001);
        check("rd_mem_en",   {15'd0, bus.mem_en}, 16'd1);
        check("rd_mem_addr", bus.mem_addr, 16'h0010);
        check("rd_mem_we",   {15'd0, bus.mem_we}, 16'd0);
        check("rd_no_ack",   {13'd0, ack_obs}, 16'd0);
        step(1);
        check("rd_ack",      {13'd0, ack_obs}, 16'h0001);
        check("rd_rdata",    bus.rdata, 16'hBEEF);
        check("rd_en_off",   {15'd0, bus.mem_en}, 16'd0);
        bus.cpu_req = 1'b0;
        step(1);
        check("rd_gnt_clr",  {13'd0, gnt_obs}, 16'd0);
        check("rd_idle",     {14'd0, dbg_state}, {14'd0, ST_IDLE});

        // DMA write 0x1234 to 0x0020, then CPU reads it back
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0020; bus.dma_wdata = 16'h1234;
        step(1);
        check("wr_gnt",       {13'd0, gnt_obs}, 16'h0002);
        check("wr_mem_we",    {15'd0, bus.mem_we}, 16'd1);
        check("wr_mem_addr",  bus.mem_addr, 16'h0020);
        check("wr_mem_wdata", bus.mem_wdata, 16'h1234);
        step(1);
        check("wr_ack",       {13'd0, ack_obs}, 16'h0002);
        check("wr_rdata",     bus.rdata, 16'd0);
        bus.dma_req = 1'b0; bus.dma_we = 1'b0;
        step(1);
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0020;
        step(2);
        check("rb_ack",       {13'd0, ack_obs}, 16'h0001);
        check("rb_rdata",     bus.rdata, 16'h1234);
        bus.cpu_req = 1'b0;
        step(1);

        // Address change during ACCESS and req dropped during RESP
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        step(1);
        bus.cpu_addr = 16'h0055; bus.cpu_we = 1'b1;
        #1;
        check("lat_mem_addr", bus.mem_addr, 16'h0010);
        check("lat_mem_we",   {15'd0, bus.mem_we}, 16'd0);
        step(1);
        bus.cpu_req = 1'b0;
        #1;
        check("drop_ack",     {13'd0, ack_obs}, 16'h0001);
        check("drop_rdata",   bus.rdata, 16'hBEEF);
        step(1);
        check("drop_ack_end", {13'd0, ack_obs}, 16'd0);
        step(1);
        check("drop_once",    {13'd0, ack_obs}, 16'd0);
        check("drop_idle",    {14'd0, dbg_state}, {14'd0, ST_IDLE});
        idle_inputs();

        // CPU + DMA continuous: four CPU grants, then DMA, repeating
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(3'b001);
            exp_q.push_back(3'b010);
        end
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
        bus.dma_req = 1'b1; bus.dma_addr = 16'h0010;
        run_grants(10);
        idle_inputs();
        step(3);

        // All three continuous; DMA was served last, so DSP takes the first tie
        exp_q = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b010,
                  3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001};
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
        bus.dma_req = 1'b1; bus.dma_addr = 16'h0010;
        bus.dsp_req = 1'b1; bus.dsp_addr = 16'h0010;
        run_grants(12);
        idle_inputs();
        step(3);

        // Reset during ACCESS of a DSP read
        bus.dsp_req = 1'b1; bus.dsp_we = 1'b0; bus.dsp_addr = 16'h0010;
        step(1);
        check("rst_pre_gnt",    {13'd0, gnt_obs}, 16'h0004);
        check("rst_pre_en",     {15'd0, bus.mem_en}, 16'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_gnt",    {13'd0, gnt_obs}, 16'd0);
        check("rst_mid_ack",    {13'd0, ack_obs}, 16'd0);
        check("rst_mid_en",     {15'd0, bus.mem_en}, 16'd0);
        check("rst_mid_we",     {15'd0, bus.mem_we}, 16'd0);
        check("rst_mid_addr",   bus.mem_addr, 16'd0);
        check("rst_mid_wdata",  bus.mem_wdata, 16'd0);
        check("rst_mid_rdata",  bus.rdata, 16'd0);
        check("rst_mid_state",  {14'd0, dbg_state}, {14'd0, ST_IDLE});
        @(negedge clk);
        if (bus.dsp_ack) dsp_ack_cnt++;
        rst = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
        step(1);
        if (bus.dsp_ack) dsp_ack_cnt++;
        check("post_rst_gnt",   {13'd0, gnt_obs}, 16'h0001);
        step(1);
        if (bus.dsp_ack) dsp_ack_cnt++;
        check("post_rst_ack",   {13'd0, ack_obs}, 16'h0001);
        check("post_rst_rdata", bus.rdata, 16'h1234);
        bus.cpu_req = 1'b0;
        step(1);
        if (bus.dsp_ack) dsp_ack_cnt++;
        step(1);
        if (bus.dsp_ack) dsp_ack_cnt++;
        check("dsp_regnt",      {13'd0, gnt_obs}, 16'h0004);
        check("dsp_no_ack",     dsp_ack_cnt[15:0], 16'd0);
        step(1);
        check("dsp_ack",        {13'd0, ack_obs}, 16'h0004);
        check("dsp_rdata",      bus.rdata, 16'hBEEF);
        idle_inputs();
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: lost arbitrations before a DMA/DSP requester outranks the CPU.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports cpu_req, dma_req, dsp_req  input  1 each  access request; held until the matching ack.
REQ-005 SHALL have ports cpu_we, dma_we, dsp_we  input  1 each  1=write, 0=read.
REQ-006 SHALL have ports cpu_addr, dma_addr, dsp_addr  input  16 each  word address.
REQ-007 SHALL have ports cpu_wdata, dma_wdata, dsp_wdata  input  16 each  write data.
REQ-008 SHALL have ports cpu_gnt, dma_gnt, dsp_gnt  output  1 each  owner of the current transaction; one-hot or all zero.
REQ-009 SHALL have ports cpu_ack, dma_ack, dsp_ack  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  16  read data, valid while any ack=1.
REQ-011 SHALL have ports mem_en  output 1, mem_we  output 1, mem_addr  output 16, mem_wdata  output 16  to a synchronous RAM.
REQ-012 SHALL have port mem_rdata  input  16  RAM read data, valid the cycle after mem_en.

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one transaction per 3 cycles.
REQ-014 IDLE: with any req high, SHALL pick a winner, latch its we/addr/wdata, set its gnt, and enter ACCESS. With no req, SHALL stay in IDLE.
REQ-015 ACCESS: SHALL drive mem_en=1 plus latched mem_we/mem_addr/mem_wdata for exactly one cycle. mem_en SHALL be 0 in all other states.
REQ-016 RESP: SHALL pulse the winner's ack for one cycle, drive rdata=mem_rdata (read) or 0 (write), then clear gnt and return to IDLE.
REQ-017 gnt SHALL stay high through ACCESS and RESP only.
REQ-018 Priority SHALL be CPU > DMA > DSP, except that a requester whose wait count equals STARVE_LIMIT SHALL beat the CPU.
REQ-019 If DMA and DSP are both starved, SHALL grant the one not served last (last_svc flag, toggled on each DMA/DSP grant).
REQ-020 Per-requester wait counter (DMA, DSP): SHALL increment at each IDLE decision where that requester is requesting and loses; SHALL saturate at STARVE_LIMIT; SHALL clear when that requester is granted or its req is low at a decision.
REQ-021 Inputs SHALL be sampled only at the IDLE decision; later changes to addr/we/wdata SHALL be ignored.
REQ-022 A req dropped after grant SHALL NOT abort the transaction; ack SHALL still pulse.
REQ-023 A req held high after its ack SHALL be treated as a new request at the next IDLE.

Reset
REQ-024 Asserting rst at any time SHALL immediately force state=IDLE, all gnt/ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, wait counters=0, last_svc=DSP.
REQ-025 A transaction interrupted by reset SHALL produce no ack. Operation SHALL resume on the first posedge after release.

Structure
REQ-026 Shared package tiny16_pkg SHALL hold requester IDs (CPU=0, DMA=1, DSP=2), FSM state encoding, and the default STARVE_LIMIT.
REQ-027 Winner selection plus wait counters and last_svc SHALL live in one sub-module, arb_select. The FSM and datapath latch SHALL stay in mem_arbiter.

Verification
REQ-028 Single CPU read, addr=0x0010, RAM[0x0010]=0xBEEF: cpu_gnt 1 cycle after req seen in IDLE, mem_en for 1 cycle, cpu_ack with rdata=0xBEEF on the 3rd cycle.
REQ-029 DMA write addr=0x0020, wdata=0x1234, then CPU read 0x0020: mem_we=1 on the write, and the CPU then reads 0x1234.
REQ-030 CPU and DMA both requesting continuously, STARVE_LIMIT=4: grant order CPU,CPU,CPU,CPU,DMA, then repeating.
REQ-031 CPU, DMA and DSP all requesting continuously: DMA and DSP alternate at the starvation grants, and DSP is never starved beyond two limit periods.
REQ-032 rst asserted during ACCESS of a DSP read: all outputs are 0 that cycle, no dsp_ack ever pulses, and the next grant after release is correct.
REQ-033 CPU changes addr during ACCESS: mem_addr keeps the latched value. CPU drops req in RESP: cpu_ack still pulses once.
